cordic_cos_scheduler: RTL and testbench
=======================================

Name: cordic_cos_scheduler

Overview:
- Shares one fully pipelined fixed-point CORDIC cosine unit between N_REQ independent requesters.
- Input and output are both IEEE-754 single precision. The unit takes a new operand every cycle, cannot stall, and has fixed latency PIPE_LATENCY.
- The block does round-robin issue and tags each operation through a valid/tag delay line. It routes each result into a per-requester response FIFO.
- It uses credit-based issue, so a result is never dropped when a consumer backpressures.

Parameters:
- N_REQ, 2, number of requesters.
- PIPE_LATENCY, 5, cycles from operand presented on cordic_in to result valid on cordic_out (one per internal pipeline register).
- FIFO_DEPTH, 8, entries per requester response FIFO; power of two.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  request valid per requester.
- req_ready  out  N_REQ  request accepted this cycle (one-hot or zero).
- req_data  in  32*N_REQ  IEEE-754 angle; requester i occupies bits [32i+31:32i].
- rsp_valid  out  N_REQ  response FIFO non-empty.
- rsp_ready  in  N_REQ  consumer pops head.
- rsp_data  out  32*N_REQ  IEEE-754 cosine at FIFO head.
- cordic_in  out  32  operand to the pipeline.
- cordic_out  in  32  pipeline result.
- busy  out  1  any operation in flight or any FIFO non-empty.

Behaviour:
- Reset (rst=0, asynchronous):
  - rsp_valid, req_ready and busy go to 0; rsp_data goes to 0.
  - Delay line valid bits, in-flight counters and FIFO pointers are cleared; round-robin pointer goes to 0.
  - In-flight operations are discarded. The pipeline's stale contents are never written because their valid bits are 0.
- Credit:
  - credit[i] = FIFO_DEPTH - count[i] - inflight[i], computed from registered values.
  - A pop in the same cycle does not raise credit until the next cycle.
- Eligibility and grant:
  - eligible[i] = req_valid[i] && credit[i] > 0.
  - Grant at most one eligible requester per cycle, searching from rr_ptr upward with wrap.
  - req_ready = grant, combinational from req_valid and registered state.
  - On a grant, rr_ptr <= granted index + 1 (mod N_REQ). With no grant, rr_ptr holds.
- Issue:
  - cordic_in = req_data of the granted requester, combinational; 32'h0 when no grant.
  - At the same edge, {1, grant index} enters stage 1 of the PIPE_LATENCY-deep valid/tag shift register. Without a grant, {0, x} enters.
  - The register shifts every cycle.
- Retire:
  - When the last delay stage is valid, cordic_out is written into FIFO[tag] at that edge, and inflight[tag] is decremented.
  - Latency: accepted in cycle t means the result is visible on rsp_valid/rsp_data in cycle t+PIPE_LATENCY+1 (t+6), provided FIFO[tag] was empty.
- In-flight counters:
  - Issue increments, retire decrements; both in the same cycle for the same requester leaves the counter unchanged.
  - Width is clog2(FIFO_DEPTH+1).
- Response FIFO:
  - Pop on rsp_valid && rsp_ready. Simultaneous write and pop leaves count unchanged.
  - Credit guarantees a write is never attempted into a full FIFO. The bench asserts this.
  - rsp_data is stable while rsp_valid=1 and rsp_ready=0.
  - Per-requester ordering equals acceptance order.
- Throughput: sustained issue of 1 per cycle across all requesters. A single requester with rsp_ready held high also sustains 1 per cycle, since FIFO_DEPTH >= PIPE_LATENCY+1.
- busy = |inflight || |count, registered-state derived.

Test Plan:
- Single issue: req_valid[0]=1 with req_data=32'h00000000 accepted at cycle t -> rsp_valid[0]=1 at t+6; rsp_data equals the standalone pipeline output (~32'h3F800000); busy high from t+1 until the pop.
- Contention: both requesters held valid, rsp_ready=2'b11, operands 32'h3F860A92 (pi/3) and 0 -> grants alternate 0,1,0,1 starting at requester 0; req 0 results ~32'h3F000000; one issue per cycle.
- Backpressure: rsp_ready[1]=0 while requester 1 offers 10 operands -> exactly 8 accepted, then req_ready[1]=0; requester 0 continues at full rate. After rsp_ready[1]=1, the remaining 2 are accepted and all 10 results emerge in order.
- Streaming: 5 back-to-back requests on requester 0 only, rsp_ready=1 -> accepted in cycles t..t+4; results in cycles t+6..t+10 in order, with no gaps.
- Reset mid-flight: rst=0 asynchronously with 3 operations in flight and 2 FIFO entries -> all outputs 0 immediately. After release, no rsp_valid for 10 cycles with no requests, and rr_ptr restarts at 0.
- Full-boundary: FIFO[0] at 7 with 1 in flight, a pop and a retire in the same cycle -> count stays 7; a new request is granted only in the following cycle.

Source files
------------

// File: rtl/cordic_cos_scheduler.sv
// cordic_cos_scheduler: shares one fixed-latency, non-stalling CORDIC cosine pipeline between
// N_REQ requesters with round-robin issue, a valid/tag delay line and credit-gated response FIFOs.

module cordic_rsp_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  output logic [31:0]   rd_data,
  output logic          not_empty,
  output logic [CW-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= wr_data;
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (wr_en) wr_ptr_next = (wr_ptr_reg == LAST) ? '0 : wr_ptr_reg + AW'(1);
    if (rd_en) rd_ptr_next = (rd_ptr_reg == LAST) ? '0 : rd_ptr_reg + AW'(1);
    if (wr_en && !rd_en)      count_next = count_reg + CW'(1);
    else if (rd_en && !wr_en) count_next = count_reg - CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Head is forced to zero when empty so the output reads 0 out of reset.
  assign not_empty = (count_reg != '0);
  assign count     = count_reg;
  assign rd_data   = not_empty ? mem[rd_ptr_reg] : 32'h0;
endmodule

module cordic_cos_scheduler #(
  parameter int N_REQ        = 2,
  parameter int PIPE_LATENCY = 5,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [32*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]      rsp_valid,
  input  logic [N_REQ-1:0]      rsp_ready,
  output logic [32*N_REQ-1:0]   rsp_data,
  output logic [31:0]           cordic_in,
  input  logic [31:0]           cordic_out,
  output logic                  busy
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [IW-1:0] LAST_REQ = IW'(N_REQ - 1);

  logic [IW-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [N_REQ-1:0] eligible, above_ptr, eligible_hi, pick_src, grant;
  logic             grant_any;
  logic [IW-1:0]    grant_idx;
  logic             dl_valid_reg [PIPE_LATENCY];
  logic [IW-1:0]    dl_tag_reg   [PIPE_LATENCY];
  logic             ret_valid;
  logic [IW-1:0]    ret_tag;
  logic [N_REQ-1:0] fifo_wr, fifo_rd, inflight_nz;

  assign ret_valid = dl_valid_reg[PIPE_LATENCY-1];
  assign ret_tag   = dl_tag_reg[PIPE_LATENCY-1];

  // Per-requester credit, in-flight counter and response FIFO.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    logic [CW-1:0] inflight_reg, inflight_next;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   used;

    assign used         = {1'b0, fifo_count} + {1'b0, inflight_reg};
    assign eligible[gi] = req_valid[gi] && (used < (CW+1)'(FIFO_DEPTH));
    assign fifo_wr[gi]  = ret_valid && (ret_tag == IW'(gi));
    assign fifo_rd[gi]  = rsp_valid[gi] && rsp_ready[gi];

    always_comb begin
      inflight_next = inflight_reg;
      if (grant[gi] && !fifo_wr[gi])      inflight_next = inflight_reg + CW'(1);
      else if (!grant[gi] && fifo_wr[gi]) inflight_next = inflight_reg - CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) inflight_reg <= '0;
      else      inflight_reg <= inflight_next;
    end

    assign inflight_nz[gi] = (inflight_reg != '0);

    cordic_rsp_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CW    (CW)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (fifo_wr[gi]),
      .wr_data   (cordic_out),
      .rd_en     (fifo_rd[gi]),
      .rd_data   (rsp_data[32*gi +: 32]),
      .not_empty (rsp_valid[gi]),
      .count     (fifo_count)
    );
  end

  // Round robin: prefer eligible requesters at or above rr_ptr, else wrap to the lowest one.
  always_comb begin
    above_ptr   = ~((N_REQ'(1) << rr_ptr_reg) - N_REQ'(1));
    eligible_hi = eligible & above_ptr;
    pick_src    = (|eligible_hi) ? eligible_hi : eligible;
    grant       = rst ? (pick_src & (~pick_src + N_REQ'(1))) : '0;
  end

  always_comb begin
    grant_idx = '0;
    cordic_in = 32'h0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant[k]) begin
        grant_idx = IW'(k);
        cordic_in = req_data[32*k +: 32];
      end
    end
  end

  assign grant_any = |grant;
  assign req_ready = grant;

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (grant_any) rr_ptr_next = (grant_idx == LAST_REQ) ? '0 : grant_idx + IW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_ptr_reg <= '0;
    else      rr_ptr_reg <= rr_ptr_next;
  end

  // Valid/tag delay line mirrors the pipeline so each result knows its owner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < PIPE_LATENCY; k++) begin
        dl_valid_reg[k] <= 1'b0;
        dl_tag_reg[k]   <= '0;
      end
    end else begin
      for (int k = PIPE_LATENCY - 1; k > 0; k--) begin
        dl_valid_reg[k] <= dl_valid_reg[k-1];
        dl_tag_reg[k]   <= dl_tag_reg[k-1];
      end
      dl_valid_reg[0] <= grant_any;
      dl_tag_reg[0]   <= grant_idx;
    end
  end

  assign busy = (|inflight_nz) | (|rsp_valid);
endmodule

// File: tb/tb_cordic_cos_scheduler.sv
// tb_cordic_cos_scheduler: directed checks of arbitration, issue, credit and retire, with a
// 5-stage bench-side stand-in for the CORDIC pipeline.
`timescale 1ns/1ps
module tb_cordic_cos_scheduler;
  localparam int N_REQ        = 2;
  localparam int PIPE_LATENCY = 5;
  localparam int FIFO_DEPTH   = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [63:0] req_data = '0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = '0;
  logic [63:0] rsp_data;
  logic [31:0] cordic_in;
  logic [31:0] cordic_out;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int outstanding [N_REQ];
  logic [31:0] pipe [PIPE_LATENCY];

  always #5 clk = ~clk;

  cordic_cos_scheduler #(
    .N_REQ        (N_REQ),
    .PIPE_LATENCY (PIPE_LATENCY),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .cordic_in  (cordic_in),
    .cordic_out (cordic_out),
    .busy       (busy)
  );

  // Stand-in cosine: exact for 0 and pi/3, otherwise a recognisable scramble.
  function automatic logic [31:0] cos_ref(input logic [31:0] x);
    case (x)
      32'h00000000: return 32'h3F800000;
      32'h3F860A92: return 32'h3F000000;
      default:      return x ^ 32'h00FF00FF;
    endcase
  endfunction

  function automatic logic [31:0] bp_val(input int i);
    return 32'h41000000 + 32'(i);
  endfunction

  function automatic logic [31:0] fb_val(input int i);
    return 32'h42100000 + 32'(i);
  endfunction

  always @(posedge clk) begin
    pipe[0] <= cos_ref(cordic_in);
    for (int k = 1; k < PIPE_LATENCY; k++) pipe[k] <= pipe[k-1];
  end
  assign cordic_out = pipe[PIPE_LATENCY-1];

  // Accepted-but-not-popped per requester must stay below FIFO_DEPTH at every accept.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_REQ; i++) outstanding[i] = 0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          tests++;
          if (outstanding[i] >= FIFO_DEPTH) begin
            fails++;
            $display("FAIL overflow_guard req%0d: outstanding %0d, required < %0d", i, outstanding[i], FIFO_DEPTH);
          end
          outstanding[i]++;
        end
        if (rsp_valid[i] && rsp_ready[i]) outstanding[i]--;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = '0;
    rst = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    req_data = {32'h3F860A92, 32'h00000000};
    @(negedge clk);
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_req_ready: got %b, expected 00", req_ready); end
    tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL reset_rsp_valid: got %b, expected 00", rsp_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    tests++; if (rsp_data !== 64'h0) begin fails++; $display("FAIL reset_rsp_data: got %h, expected 0", rsp_data); end
    tests++; if (cordic_in !== 32'h0) begin fails++; $display("FAIL reset_cordic_in: got %h, expected 0", cordic_in); end
    $display("[TB] reset: req_ready=%b rsp_valid=%b busy=%b", req_ready, rsp_valid, busy);
    next_cycle();
    req_valid = '0;
    rsp_ready = '0;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests++;
      if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
        fails++; $display("FAIL reset_idle c%0d: rsp_valid=%b busy=%b, expected 00/0", k, rsp_valid, busy);
      end
      next_cycle();
    end
  endtask

  task automatic test_contention();
    logic [1:0]  exp_g, exp_v;
    logic [31:0] exp_in;
    do_reset();
    req_data  = {32'h00000000, 32'h3F860A92};
    rsp_ready = 2'b11;
    for (int k = 0; k < 16; k++) begin
      req_valid = (k < 8) ? 2'b11 : 2'b00;
      @(negedge clk);
      if (k < 8) begin
        exp_g  = (k % 2 == 0) ? 2'b01 : 2'b10;
        exp_in = (k % 2 == 0) ? 32'h3F860A92 : 32'h0;
        tests++; if (req_ready !== exp_g) begin fails++; $display("FAIL contention_grant c%0d: got %b, expected %b", k, req_ready, exp_g); end
        tests++; if (cordic_in !== exp_in) begin fails++; $display("FAIL contention_operand c%0d: got %h, expected %h", k, cordic_in, exp_in); end
      end
      exp_v = (k >= 6 && k <= 13) ? ((k % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      tests++; if (rsp_valid !== exp_v) begin fails++; $display("FAIL contention_rsp_valid c%0d: got %b, expected %b", k, rsp_valid, exp_v); end
      if (exp_v == 2'b01) begin
        tests++; if (rsp_data[31:0] !== 32'h3F000000) begin fails++; $display("FAIL contention_rsp0 c%0d: got %h, expected 3f000000", k, rsp_data[31:0]); end
      end
      if (exp_v == 2'b10) begin
        tests++; if (rsp_data[63:32] !== 32'h3F800000) begin fails++; $display("FAIL contention_rsp1 c%0d: got %h, expected 3f800000", k, rsp_data[63:32]); end
      end
      $display("[TB] contention c%0d: grant=%b rsp_valid=%b", k, req_ready, rsp_valid);
      next_cycle();
    end
  endtask

  task automatic test_single();
    do_reset();
    req_data = 64'h0;
    for (int k = 0; k < 8; k++) begin
      req_valid = (k == 0) ? 2'b01 : 2'b00;
      rsp_ready = (k == 6) ? 2'b01 : 2'b00;
      @(negedge clk);
      if (k == 0) begin
        tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL single_accept: got %b, expected 01", req_ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_t0: got %b, expected 0", busy); end
      end else if (k <= 6) begin
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy c%0d: got %b, expected 1", k, busy); end
        tests++; if (rsp_valid !== ((k == 6) ? 2'b01 : 2'b00)) begin fails++; $display("FAIL single_rsp_valid c%0d: got %b, expected %b", k, rsp_valid, (k == 6) ? 2'b01 : 2'b00); end
      end
      if (k == 6) begin
        tests++; if (rsp_data[31:0] !== 32'h3F800000) begin fails++; $display("FAIL single_rsp_data: got %h, expected 3f800000", rsp_data[31:0]); end
      end
      if (k == 7) begin
        tests++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin fails++; $display("FAIL single_after_pop: rsp_valid=%b busy=%b, expected 00/0", rsp_valid, busy); end
      end
      $display("[TB] single c%0d: ready=%b rsp_valid=%b busy=%b", k, req_ready, rsp_valid, busy);
      next_cycle();
    end
  endtask

  task automatic test_streaming();
    logic [1:0]  exp_v;
    logic [31:0] exp_d;
    do_reset();
    rsp_ready = 2'b01;
    for (int k = 0; k < 13; k++) begin
      req_valid = (k < 5) ? 2'b01 : 2'b00;
      req_data[31:0] = 32'h40490FDB + 32'(k);
      @(negedge clk);
      tests++; if (req_ready !== ((k < 5) ? 2'b01 : 2'b00)) begin fails++; $display("FAIL stream_ready c%0d: got %b, expected %b", k, req_ready, (k < 5) ? 2'b01 : 2'b00); end
      exp_v = (k >= 6 && k <= 10) ? 2'b01 : 2'b00;
      tests++; if (rsp_valid !== exp_v) begin fails++; $display("FAIL stream_rsp_valid c%0d: got %b, expected %b", k, rsp_valid, exp_v); end
      if (exp_v == 2'b01) begin
        exp_d = cos_ref(32'h40490FDB + 32'(k - 6));
        tests++; if (rsp_data[31:0] !== exp_d) begin fails++; $display("FAIL stream_rsp_data c%0d: got %h, expected %h", k, rsp_data[31:0], exp_d); end
      end
      $display("[TB] stream c%0d: ready=%b rsp_valid=%b data=%h", k, req_ready, rsp_valid, rsp_data[31:0]);
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    int i1 = 0;
    int n1 = 0;
    logic [1:0]  exp_g;
    logic [31:0] exp_d;
    do_reset();
    rsp_ready = 2'b01;
    for (int k = 0; k < 20; k++) begin
      req_valid = {(i1 < 10), 1'b1};
      req_data  = {bp_val(i1), 32'h00000000};
      @(negedge clk);
      exp_g = (k < 16) ? ((k % 2 == 0) ? 2'b01 : 2'b10) : 2'b01;
      tests++; if (req_ready !== exp_g) begin fails++; $display("FAIL bp_grant c%0d: got %b, expected %b", k, req_ready, exp_g); end
      if (rsp_valid[0]) begin
        tests++; if (rsp_data[31:0] !== 32'h3F800000) begin fails++; $display("FAIL bp_rsp0 c%0d: got %h, expected 3f800000", k, rsp_data[31:0]); end
      end
      if (req_ready[1]) i1++;
      $display("[TB] backpressure c%0d: grant=%b accepted1=%0d", k, req_ready, i1);
      next_cycle();
    end
    tests++; if (i1 !== 8) begin fails++; $display("FAIL bp_accepted_before_release: got %0d, expected 8", i1); end
    for (int k = 20; k < 50; k++) begin
      req_valid = {(i1 < 10), 1'b0};
      req_data  = {bp_val(i1), 32'h00000000};
      rsp_ready = 2'b11;
      @(negedge clk);
      if (k == 20) begin
        tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL bp_pop_no_same_cycle_credit: got %b, expected 00", req_ready); end
      end
      if (k == 21 || k == 22) begin
        tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL bp_resume c%0d: got %b, expected 10", k, req_ready); end
      end
      if (rsp_valid[1]) begin
        exp_d = cos_ref(bp_val(n1));
        tests++; if (rsp_data[63:32] !== exp_d) begin fails++; $display("FAIL bp_order n%0d: got %h, expected %h", n1, rsp_data[63:32], exp_d); end
        $display("[TB] backpressure pop1 n%0d: data=%h", n1, rsp_data[63:32]);
        n1++;
      end
      if (req_ready[1]) i1++;
      next_cycle();
    end
    tests++; if (n1 !== 10) begin fails++; $display("FAIL bp_results: got %0d, expected 10", n1); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL bp_drained_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_full_boundary();
    int acc = 0;
    int n = 1;
    logic [1:0]  exp_g;
    logic [31:0] exp_d;
    do_reset();
    for (int k = 0; k < 15; k++) begin
      req_valid = 2'b01;
      req_data[31:0] = fb_val(acc);
      rsp_ready = (k == 12) ? 2'b01 : 2'b00;
      @(negedge clk);
      exp_g = (k < 8 || k == 13) ? 2'b01 : 2'b00;
      tests++; if (req_ready !== exp_g) begin fails++; $display("FAIL full_grant c%0d: got %b, expected %b", k, req_ready, exp_g); end
      if (k == 12) begin
        tests++; if (rsp_valid[0] !== 1'b1 || rsp_data[31:0] !== cos_ref(fb_val(0))) begin
          fails++; $display("FAIL full_head: valid=%b data=%h, expected 1/%h", rsp_valid[0], rsp_data[31:0], cos_ref(fb_val(0)));
        end
      end
      if (req_ready[0]) acc++;
      $display("[TB] full c%0d: grant=%b accepted=%0d", k, req_ready, acc);
      next_cycle();
    end
    tests++; if (acc !== 9) begin fails++; $display("FAIL full_accepted: got %0d, expected 9", acc); end
    req_valid = 2'b00;
    rsp_ready = 2'b01;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid[0]) begin
        exp_d = cos_ref(fb_val(n));
        tests++; if (rsp_data[31:0] !== exp_d) begin fails++; $display("FAIL full_order n%0d: got %h, expected %h", n, rsp_data[31:0], exp_d); end
        n++;
      end
      next_cycle();
    end
    tests++; if (n !== 9) begin fails++; $display("FAIL full_drain: got %0d, expected 9", n); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL full_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    rsp_ready = 2'b00;
    for (int k = 0; k < 8; k++) begin
      req_valid = (k < 5) ? 2'b01 : 2'b00;
      req_data[31:0] = fb_val(k);
      @(negedge clk);
      if (k < 7) next_cycle();
    end
    tests++; if (rsp_valid !== 2'b01 || busy !== 1'b1) begin fails++; $display("FAIL midflight_pre: rsp_valid=%b busy=%b, expected 01/1", rsp_valid, busy); end
    #2;
    req_valid = 2'b11;
    rst = 1'b0;
    #1;
    tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL midflight_rsp_valid: got %b, expected 00", rsp_valid); end
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL midflight_req_ready: got %b, expected 00", req_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midflight_busy: got %b, expected 0", busy); end
    tests++; if (rsp_data !== 64'h0) begin fails++; $display("FAIL midflight_rsp_data: got %h, expected 0", rsp_data); end
    tests++; if (cordic_in !== 32'h0) begin fails++; $display("FAIL midflight_cordic_in: got %h, expected 0", cordic_in); end
    $display("[TB] midflight reset: rsp_valid=%b req_ready=%b busy=%b", rsp_valid, req_ready, busy);
    next_cycle();
    next_cycle();
    req_valid = 2'b00;
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      tests++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin fails++; $display("FAIL midflight_quiet c%0d: rsp_valid=%b busy=%b, expected 00/0", k, rsp_valid, busy); end
      next_cycle();
    end
    req_valid = 2'b11;
    @(negedge clk);
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL midflight_rr_restart: got %b, expected 01", req_ready); end
    $display("[TB] midflight restart grant=%b", req_ready);
    next_cycle();
    req_valid = 2'b00;
  endtask

  initial begin
    next_cycle();
    test_reset();
    test_contention();
    test_single();
    test_streaming();
    test_backpressure();
    test_full_boundary();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
